// File: rtl/result_byte_serializer_if.sv
// Element-in / byte-out bundle for result_byte_serializer.
// slave is the serializer's view; master is the view of whatever drives it.
interface result_byte_serializer_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  logic [WIDTH-1:0]         in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [7:0]               tx_data;
  logic                     tx_start;
  logic                     tx_busy;
  logic                     frame_done;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    output in_data, in_valid, tx_busy,
    input  in_ready, tx_data, tx_start, frame_done, fifo_count
  );

  modport slave (
    input  in_data, in_valid, tx_busy,
    output in_ready, tx_data, tx_start, frame_done, fifo_count
  );
endinterface

// File: rtl/result_byte_serializer.sv
// Buffers WIDTH-bit elements in a FIFO and feeds them MSB-byte-first to a UART TX.
// Define SERIALIZER_CHECKSUM_EN to append an XOR checksum byte after each frame.
module result_byte_serializer #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  result_byte_serializer_if.slave bus
);
  localparam int BYTES  = WIDTH / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int ECNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_ACK, S_WAIT_DONE
`ifdef SERIALIZER_CHECKSUM_EN
    , S_CSUM, S_CK_ACK, S_CK_DONE
`endif
  } state_e;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [BIDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [ECNT_W-1:0] elem_cnt_q, elem_cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              frame_done_q, frame_done_d;
`ifdef SERIALIZER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic [7:0]        top_byte;
  logic              last_byte, last_elem;

  // A full FIFO refuses input even when a pop frees a slot that cycle.
  assign bus.in_ready = (count_q != CNT_W'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state_q == S_IDLE) && (count_q != '0);

  assign top_byte  = shift_q[WIDTH-1 -: 8];
  assign last_byte = (byte_idx_q == BIDX_W'(BYTES - 1));
  assign last_elem = (elem_cnt_q == ECNT_W'(FRAME_LEN - 1));

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= '0;
      elem_cnt_q   <= '0;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SERIALIZER_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      elem_cnt_q   <= elem_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      frame_done_q <= frame_done_d;
`ifdef SERIALIZER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (count_q != '0) state_d = S_SEND;
      S_SEND:      state_d = S_WAIT_ACK;
      S_WAIT_ACK:  if (bus.tx_busy) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (!last_byte)      state_d = S_SEND;
          else if (!last_elem) state_d = S_IDLE;
          else begin
`ifdef SERIALIZER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_IDLE;
`endif
          end
        end
      end
`ifdef SERIALIZER_CHECKSUM_EN
      S_CSUM:      state_d = S_CK_ACK;
      S_CK_ACK:    if (bus.tx_busy) state_d = S_CK_DONE;
      S_CK_DONE:   if (!bus.tx_busy) state_d = S_IDLE;
`endif
      default:     state_d = S_IDLE;
    endcase
  end

  // tx_start/tx_data are registered, so the request appears the cycle after SEND.
  always_comb begin
    shift_d      = shift_q;
    byte_idx_d   = byte_idx_q;
    elem_cnt_d   = elem_cnt_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    frame_done_d = 1'b0;
`ifdef SERIALIZER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d    = mem_q[rd_ptr_q];
          byte_idx_d = '0;
        end
      end
      S_SEND: begin
        tx_data_d  = top_byte;
        tx_start_d = 1'b1;
`ifdef SERIALIZER_CHECKSUM_EN
        csum_d     = csum_q ^ top_byte;
`endif
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (!last_byte) begin
            shift_d    = shift_q << 8;
            byte_idx_d = byte_idx_q + BIDX_W'(1);
          end else if (!last_elem) begin
            elem_cnt_d = elem_cnt_q + ECNT_W'(1);
          end else begin
`ifndef SERIALIZER_CHECKSUM_EN
            frame_done_d = 1'b1;
            elem_cnt_d   = '0;
`endif
          end
        end
      end
`ifdef SERIALIZER_CHECKSUM_EN
      S_CSUM: begin
        tx_data_d  = csum_q;
        tx_start_d = 1'b1;
      end
      S_CK_DONE: begin
        if (!bus.tx_busy) begin
          frame_done_d = 1'b1;
          csum_d       = 8'h00;
          elem_cnt_d   = '0;
        end
      end
`endif
      default: ;
    endcase
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.frame_done = frame_done_q;
  assign bus.fifo_count = count_q;
endmodule

// File: doc/result_byte_serializer.md
# result_byte_serializer

Upstream feeder for the UART transmitter: accepts WIDTH-bit matrix-result elements from the multiplier datapath over a valid/ready handshake and buffers them in a small FIFO. It splits each element into bytes, most significant byte first, and hands them one at a time to the UART TX through its data/start/busy interface. Elements are grouped into frames of FRAME_LEN; an optional XOR checksum byte closes each frame.

## Interface
- WIDTH, 16: element width in bits; multiple of 8, 8..32.
- DEPTH, 8: FIFO depth in elements; power of 2, ≥2.
- FRAME_LEN, 9: elements per frame (3x3 result matrix); ≥1.
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  WIDTH  element from multiplier.
- in_valid  input  1  in_data valid.
- in_ready  output  1  FIFO can accept; transfer on in_valid && in_ready at a clk edge.
- tx_data  output  8  byte to UART TX `data`; held stable from tx_start until tx_busy falls.
- tx_start  output  1  one-cycle request to UART TX `start`.
- tx_busy  input  1  UART TX `busy`.
- frame_done  output  1  one-cycle pulse after the last byte of a frame completes.
- fifo_count  output  $clog2(DEPTH)+1  elements currently stored in FIFO.

## Operation
- FIFO: DEPTH entries; binary read/write pointers with wrap; registered count.
  - in_ready = (fifo_count != DEPTH). When full, input is refused even if a pop occurs in the same cycle.
  - Simultaneous push and pop leaves the count unchanged.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop the head into the shift register, byte_idx=0, go to SEND. If empty, stay.
  - SEND: tx_data = shift register top byte (bits WIDTH-1:WIDTH-8 for byte 0); tx_start=1 for exactly this one cycle; go to WAIT_ACK.
  - WAIT_ACK: wait for tx_busy=1, then go to WAIT_DONE. No timeout.
  - WAIT_DONE: wait for tx_busy=0, then act on the position in the element and frame:
    - More bytes left in the element: shift left 8, byte_idx+1, go to SEND.
    - Last byte of the element, frame not complete: elem_cnt+1, go to IDLE.
    - Last byte of the frame with checksum enabled: go to CSUM.
    - Last byte of the frame with checksum disabled: pulse frame_done, elem_cnt=0, go to IDLE.
  - CSUM (only with checksum enabled): tx_data = checksum, tx_start=1 for one cycle; go to CK_ACK.
  - CK_ACK: wait for tx_busy=1, then go to CK_DONE.
  - CK_DONE: wait for tx_busy=0; then pulse frame_done, clear checksum, elem_cnt=0, go to IDLE.
- Bytes per element = WIDTH/8. elem_cnt counts 0..FRAME_LEN-1 and wraps to 0 at each frame end.
- Reset mid-operation clears everything:
  - FIFO emptied, pointers and count zeroed.
  - FSM returns to IDLE, tx_start drops the next cycle.
  - elem_cnt and checksum zeroed.
  - A byte already in flight in the UART TX is abandoned and not retransmitted.

## Timing
- Reset values: in_ready=1, tx_data=0x00, tx_start=0, frame_done=0, fifo_count=0; FSM in IDLE.
- All outputs registered except in_ready, which is decoded from the registered count.
- Latency: element accepted at edge E into an empty FIFO, FSM in IDLE → pop at edge E+1 → tx_start high for the cycle after edge E+2.
- tx_start is never reasserted while tx_busy=1, or before tx_busy has been seen to rise and then fall for the previous byte.
- Byte-to-byte gap: 1 cycle (SEND) after tx_busy is seen low, plus the UART TX's own idle-to-busy cycle.
- frame_done is high for the cycle after the edge at which the final tx_busy=0 is sampled.
- A fully stalled tx_busy=1 holds the FSM indefinitely. The FIFO keeps accepting input until full.
- Capacity: DEPTH elements in the FIFO plus 1 in the shift register.

## Configuration
- SERIALIZER_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR of every data byte sent in the frame is appended as one extra byte after the frame's last data byte.
  - The checksum accumulates at each SEND.
  - frame_done fires after the checksum byte completes.
- Undefined: the CSUM/CK_ACK/CK_DONE states and the checksum register are absent; frame_done fires after the last data byte.

## Test plan
- Single element 0x1234, UART TX model (busy high 1 cycle after start, for 10 cycles) → two tx_start pulses, tx_data 0x12 then 0x34; each start issued only after the previous busy has fallen.
- Elements 0x0001..0x0009 with SERIALIZER_CHECKSUM_EN → 18 data bytes 0x00,0x01,…,0x00,0x09, then checksum byte 0x01, then one frame_done pulse. Without the macro → 18 bytes, with frame_done after the last byte.
- Hold tx_busy=1 and push continuously → in_ready drops after DEPTH+1 = 9 accepts with fifo_count=8; a 10th in_valid is not accepted.
- Push and pop in the same cycle at fifo_count=4 → count stays 4; pointer wrap over 20 elements → output order equals input order.
- Assert rst during WAIT_DONE of byte 1 with 3 elements queued → next cycle: fifo_count=0, tx_start=0, in_ready=1, tx_data=0x00; no further tx_start until a new push.
- in_valid pulses with a 1-cycle gap during frame transmission → no element lost or duplicated; elem_cnt wraps so the second frame's checksum covers only its own bytes.
